// File: rtl/sc_backg_scrollregister_if.sv
// Strobe/enable and row-bank bundle between the background state machine and
// the background scroll register.
interface sc_backg_scrollregister_if #(
   parameter int DATAWIDTH_BUS = 8,
   parameter int ROWS          = 8
);
   logic                            clear_InLow;
   logic                            load_InLow;
   logic                            upcount_In;
   logic                            T0_OutLow;
   logic [ROWS*DATAWIDTH_BUS-1:0]   data_OutBus;
   logic [15:0]                     scrollCount_OutBus;

   modport master (
      output clear_InLow, load_InLow, upcount_In,
      input  T0_OutLow, data_OutBus, scrollCount_OutBus
   );

   modport slave (
      input  clear_InLow, load_InLow, upcount_In,
      output T0_OutLow, data_OutBus, scrollCount_OutBus
   );
endinterface

// File: rtl/sc_backg_scrollregister.sv
// Background scroll register: prescaled scroll-tick request, plus a row bank that
// shifts down one row per load and takes the next road-pattern word at the top.
module sc_backg_scrollregister #(
   parameter int          DATAWIDTH_BUS = 8,
   parameter int          ROWS          = 8,
   parameter logic [23:0] TICK_MAX      = 24'd2500000,
   parameter int          PATTERN_LEN   = 16
) (
   input logic                        SC_BACKGSCROLL_CLOCK_50,
   input logic                        SC_BACKGSCROLL_RESET_InHigh,
   sc_backg_scrollregister_if.slave   bus
);
   localparam int PTR_W = $clog2(PATTERN_LEN);

   logic [23:0]                          tick_cnt;
   logic                                 pending;
   logic [PTR_W-1:0]                     ptr;
   logic [ROWS-1:0][DATAWIDTH_BUS-1:0]   rows;
   logic [15:0]                          scroll_count;

   logic                                 wrap;
   logic                                 load;
   logic [DATAWIDTH_BUS-1:0]             next_word;

   // Road edges on the outer bits; every fourth word adds the centre lane marking.
   function automatic logic [DATAWIDTH_BUS-1:0] pattern_word(input logic [PTR_W-1:0] k);
      logic [DATAWIDTH_BUS-1:0] w;
      w = '0;
      w[DATAWIDTH_BUS-1] = 1'b1;
      w[0]               = 1'b1;
      if (k[1:0] == 2'b00) begin
         w[DATAWIDTH_BUS/2]   = 1'b1;
         w[DATAWIDTH_BUS/2-1] = 1'b1;
      end
      return w;
   endfunction

   assign wrap      = bus.upcount_In && (tick_cnt == TICK_MAX - 24'd1);
   assign load      = ~bus.load_InLow;
   assign next_word = pattern_word(ptr);

   // NOTE: the row bank is real visible state, so it is reset with everything
   // else; sequential state is only ever assigned with <= so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge SC_BACKGSCROLL_CLOCK_50) begin
      if (SC_BACKGSCROLL_RESET_InHigh || !bus.clear_InLow) begin
         tick_cnt     <= '0;
         pending      <= 1'b0;
         ptr          <= '0;
         rows         <= '0;
         scroll_count <= '0;
      end else begin
         if (bus.upcount_In)
            tick_cnt <= wrap ? 24'd0 : tick_cnt + 24'd1;
         // A wrap landing on the servicing load re-arms, so no tick is dropped.
         pending <= wrap | (pending & bus.load_InLow);
         if (load) begin
            rows         <= {rows[ROWS-2:0], next_word};
            ptr          <= ptr + 1'b1;
            scroll_count <= scroll_count + 16'd1;
         end
      end
   end

   assign bus.T0_OutLow          = ~pending;
   assign bus.data_OutBus        = rows;
   assign bus.scrollCount_OutBus = scroll_count;
endmodule

// File: tb/tb_sc_backg_scrollregister.sv
// Randomised and directed bench for sc_backg_scrollregister against a queue-based
// reference model of the scroll register.
module tb_sc_backg_scrollregister;
   localparam int          W        = 8;
   localparam int          R        = 8;
   localparam logic [23:0] TMAX     = 24'd4;
   localparam int          PLEN     = 16;

   logic clk = 1'b0;
   logic rst;

   sc_backg_scrollregister_if #(.DATAWIDTH_BUS(W), .ROWS(R)) bus ();

   sc_backg_scrollregister #(
      .DATAWIDTH_BUS (W),
      .ROWS          (R),
      .TICK_MAX      (TMAX),
      .PATTERN_LEN   (PLEN)
   ) dut (
      .SC_BACKGSCROLL_CLOCK_50     (clk),
      .SC_BACKGSCROLL_RESET_InHigh (rst),
      .bus                         (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: count of enabled clocks since last wrap, request flag,
   // pattern index, rows as a queue (front = top row), loads serviced.
   int         m_tick;
   bit         m_pending;
   int         m_ptr;
   logic [W-1:0] m_rows[$];
   int         m_count;

   function automatic logic [W-1:0] ref_pattern(input int k);
      return (k % 4 == 0) ? 8'b1001_1001 : 8'b1000_0001;
   endfunction

   function automatic logic [R*W-1:0] ref_data();
      logic [R*W-1:0] d;
      d = '0;
      for (int i = 0; i < R; i++) d[i*W +: W] = m_rows[i];
      return d;
   endfunction

   task automatic model_reset();
      m_tick    = 0;
      m_pending = 0;
      m_ptr     = 0;
      m_count   = 0;
      m_rows.delete();
      for (int i = 0; i < R; i++) m_rows.push_back('0);
   endtask

   task automatic model_edge(input bit r, input bit clr_n, input bit ld_n, input bit up);
      bit wrap_now;
      if (r || !clr_n) begin
         model_reset();
      end else begin
         wrap_now = up && (m_tick == int'(TMAX) - 1);
         if (up) m_tick = wrap_now ? 0 : m_tick + 1;
         m_pending = wrap_now || (m_pending && ld_n);
         if (!ld_n) begin
            m_rows.push_front(ref_pattern(m_ptr));
            void'(m_rows.pop_back());
            m_ptr   = (m_ptr + 1) % PLEN;
            m_count = (m_count + 1) % 65536;
         end
      end
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".t0"},    64'(bus.T0_OutLow),          64'(!m_pending));
      check({tag, ".data"},  64'(bus.data_OutBus),        64'(ref_data()));
      check({tag, ".count"}, 64'(bus.scrollCount_OutBus), 64'(m_count));
   endtask

   // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
   task automatic step(input bit r, input bit clr_n, input bit ld_n, input bit up,
                       input string tag);
      rst             = r;
      bus.clear_InLow = clr_n;
      bus.load_InLow  = ld_n;
      bus.upcount_In  = up;
      @(posedge clk);
      model_edge(r, clr_n, ld_n, up);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      bus.clear_InLow = 1'b1;
      bus.load_InLow  = 1'b1;
      bus.upcount_In  = 1'b0;

      // Reset for two edges, then the prescaler needs four enabled counts.
      step(1, 1, 1, 0, "reset0");
      step(1, 1, 1, 0, "reset1");
      check("reset_t0", 64'(bus.T0_OutLow), 64'd1);
      check("reset_data", 64'(bus.data_OutBus), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 1, "count_pre");
         check("t0_not_yet", 64'(bus.T0_OutLow), 64'd1);
      end
      step(0, 1, 1, 1, "count_wrap");
      check("t0_falls", 64'(bus.T0_OutLow), 64'd0);

      // Single-cycle load services the request.
      step(0, 1, 0, 0, "handshake");
      check("hs_row0", 64'(bus.data_OutBus[W-1:0]), 64'h99);
      check("hs_count", 64'(bus.scrollCount_OutBus), 64'd1);
      check("hs_t0", 64'(bus.T0_OutLow), 64'd1);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, "hs_hold");

      // Enable low for 10 cycles: no progress; then a wrap needs all 4 counts.
      step(1, 1, 1, 0, "rst_hold");
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0, "up_off");
      for (int i = 0; i < 4; i++) step(0, 1, 1, 1, "up_on");
      check("up_on_t0", 64'(bus.T0_OutLow), 64'd0);

      // Nine loads: row0 = pattern[8], row7 = pattern[1].
      step(1, 1, 1, 0, "rst_pat");
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0, "pat_load");
      check("pat_row0", 64'(bus.data_OutBus[W-1:0]), 64'h99);
      check("pat_row7", 64'(bus.data_OutBus[7*W +: W]), 64'h81);
      step(0, 1, 0, 0, "pat_ptr9");
      check("pat_ptr9_row0", 64'(bus.data_OutBus[W-1:0]), 64'h81);

      // Load lands on the wrap edge: shift happens and request re-arms.
      step(1, 1, 1, 0, "rst_sim");
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, "sim_pre");
      step(0, 1, 0, 1, "sim_edge");
      check("sim_t0_low", 64'(bus.T0_OutLow), 64'd0);
      check("sim_count", 64'(bus.scrollCount_OutBus), 64'd1);
      step(0, 1, 0, 0, "sim_second");
      check("sim_t0_high", 64'(bus.T0_OutLow), 64'd1);

      // Clear beats a simultaneous load.
      step(0, 0, 0, 1, "clear_prio");
      check("clear_data", 64'(bus.data_OutBus), 64'd0);
      check("clear_count", 64'(bus.scrollCount_OutBus), 64'd0);

      // Random mixed traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) < 2),
              !($urandom_range(0, 99) < 4),
              !($urandom_range(0, 99) < 30),
              ($urandom_range(0, 99) < 70),
              "random");
      end

      // 65536 loads from reset: count wraps to 0, pattern pointer back to 0.
      step(1, 1, 1, 0, "rst_wrap");
      for (int i = 0; i < 65535; i++) step(0, 1, 0, 0, "bulk");
      check("bulk_ffff", 64'(bus.scrollCount_OutBus), 64'hFFFF);
      step(0, 1, 0, 0, "bulk_wrap");
      check("count_wrap", 64'(bus.scrollCount_OutBus), 64'd0);
      step(0, 1, 0, 0, "ptr_wrap");
      check("ptr_wrap_row0", 64'(bus.data_OutBus[W-1:0]), 64'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
